// File: rtl/multi_cycle_cpu.sv
// multi_cycle_cpu: five-state multi-cycle MIPS-subset CPU with a 32-entry register file.
// Define MULTI_CYCLE_CPU_BRANCH_EN to add beq/bne/j; otherwise those opcodes run as 3-cycle NOPs.
module multi_cycle_cpu #(
    parameter int DATA_W  = 32,
    parameter int IMEM_AW = 6,
    parameter int DMEM_AW = 6
) (
    input  logic               clk_i,
    input  logic               rst_i,
    output logic [IMEM_AW-1:0] imem_addr_o,
    input  logic [31:0]        imem_data_i,
    output logic [DMEM_AW-1:0] dmem_addr_o,
    output logic [DATA_W-1:0]  dmem_wdata_o,
    output logic               dmem_we_o,
    input  logic [DATA_W-1:0]  dmem_rdata_i,
    output logic [DATA_W-1:0]  alu_out_o,
    output logic               alu_of_o,
    output logic               alu_zf_o,
    output logic [2:0]         state_o,
    output logic               instr_done_o
);
    localparam int PW = IMEM_AW + 2;
    localparam logic [5:0] OP_R = 6'h00, OP_ADDI = 6'h08, OP_ANDI = 6'h0C, OP_ORI = 6'h0D;
    localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B;

    typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4} state_e;

    state_e            state_q;
    logic [PW-1:0]     pc_q, pc_exec;
    logic [31:0]       ir_q;
    logic [DATA_W-1:0] a_q, b_q, imm_q, alu_q;
    logic              of_q, zf_q, we_q, done_q;
    logic [DATA_W-1:0] rf_q [32];
    logic [DATA_W-1:0] alu_d, zimm;
    logic              of_d, alu_en;
    logic [5:0]        op, fn;
    logic [4:0]        wdst;

    // Instructions that finish in EXEC: unknown opcodes/functs and control transfers.
    function automatic logic short_op(input logic [5:0] o, input logic [5:0] f);
        return (o == OP_R) ? !(f inside {6'h00, 6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A})
                           : !(o inside {OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW});
    endfunction

    always_comb begin
        op     = ir_q[31:26];
        fn     = ir_q[5:0];
        zimm   = DATA_W'(ir_q[15:0]);
        alu_d  = '0;
        of_d   = 1'b0;
        alu_en = !short_op(op, fn);
        wdst   = (op == OP_R) ? ir_q[15:11] : ir_q[20:16];
        if (op == OP_R) begin
            case (fn)
                6'h20: begin
                    alu_d = a_q + b_q;
                    of_d  = (a_q[DATA_W-1] == b_q[DATA_W-1]) && (alu_d[DATA_W-1] != a_q[DATA_W-1]);
                end
                6'h22: begin
                    alu_d = a_q - b_q;
                    of_d  = (a_q[DATA_W-1] != b_q[DATA_W-1]) && (alu_d[DATA_W-1] != a_q[DATA_W-1]);
                end
                6'h24:   alu_d = a_q & b_q;
                6'h25:   alu_d = a_q | b_q;
                6'h26:   alu_d = a_q ^ b_q;
                6'h27:   alu_d = ~(a_q | b_q);
                6'h2A:   alu_d = DATA_W'($signed(a_q) < $signed(b_q));
                6'h00:   alu_d = b_q << ir_q[10:6];
                default: alu_d = '0;
            endcase
        end else begin
            case (op)
                OP_ADDI: begin
                    alu_d = a_q + imm_q;
                    of_d  = (a_q[DATA_W-1] == imm_q[DATA_W-1]) && (alu_d[DATA_W-1] != a_q[DATA_W-1]);
                end
                OP_ANDI:      alu_d = a_q & zimm;
                OP_ORI:       alu_d = a_q | zimm;
                OP_LW, OP_SW: alu_d = a_q + imm_q;
                default:      alu_d = '0;
            endcase
        end
`ifdef MULTI_CYCLE_CPU_BRANCH_EN
        pc_exec = ((op == 6'h04 && a_q == b_q) || (op == 6'h05 && a_q != b_q)) ? pc_q + {imm_q[PW-3:0], 2'b00}
                : (op == 6'h02) ? {ir_q[PW-3:0], 2'b00} : pc_q;
`else
        pc_exec = pc_q;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            alu_q   <= '0;
            of_q    <= 1'b0;
            zf_q    <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                FETCH: begin
                    pc_q    <= pc_q + PW'(4);
                    state_q <= DECODE;
                end
                DECODE: begin
                    ir_q    <= imem_data_i;
                    a_q     <= rf_q[imem_data_i[25:21]];
                    b_q     <= rf_q[imem_data_i[20:16]];
                    imm_q   <= DATA_W'($signed(imem_data_i[15:0]));
                    done_q  <= short_op(imem_data_i[31:26], imem_data_i[5:0]);
                    state_q <= EXEC;
                end
                EXEC: begin
                    if (alu_en) begin
                        alu_q <= alu_d;
                        of_q  <= of_d;
                        zf_q  <= (alu_d == '0);
                    end
                    pc_q    <= pc_exec;
                    we_q    <= (op == OP_SW);
                    done_q  <= (op == OP_SW) || (alu_en && op != OP_LW);
                    state_q <= !alu_en ? FETCH : (op == OP_LW || op == OP_SW) ? MEM : WB;
                end
                MEM: begin
                    done_q  <= (op == OP_LW);
                    state_q <= (op == OP_LW) ? WB : FETCH;
                end
                WB: begin
                    // An overflowing add/sub/addi completes but leaves the register file untouched.
                    if (wdst != 5'd0 && (op == OP_LW || !of_q))
                        rf_q[wdst] <= (op == OP_LW) ? dmem_rdata_i : alu_q;
                    state_q <= FETCH;
                end
                default: state_q <= FETCH;
            endcase
        end
    end

    assign imem_addr_o  = pc_q[PW-1:2];
    assign dmem_addr_o  = alu_q[DMEM_AW+1:2];
    assign dmem_wdata_o = b_q;
    assign dmem_we_o    = we_q && !rst_i;
    assign alu_out_o    = alu_q;
    assign alu_of_o     = of_q;
    assign alu_zf_o     = zf_q;
    assign state_o      = state_q;
    assign instr_done_o = done_q;
endmodule

// File: tb/tb_multi_cycle_cpu.sv
// tb_multi_cycle_cpu: directed and random programs checked against an instruction-level model
// (architectural registers, memory, PC and per-instruction latency).
module tb_multi_cycle_cpu;
    logic        clk = 1'b0, rst = 1'b1;
    logic [5:0]  imem_addr, dmem_addr;
    logic [31:0] imem_data, dmem_wdata, dmem_rdata, alu_out;
    logic        dmem_we, alu_of, alu_zf, instr_done;
    logic [2:0]  state;
    logic [31:0] rom [64];
    logic [31:0] ram [64];
    logic [31:0] m_rf [32];
    logic [31:0] m_mem [64];
    logic [7:0]  m_pc;
    logic [31:0] m_alu;
    bit          m_of, m_zf;
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;

    multi_cycle_cpu dut (
        .clk_i(clk), .rst_i(rst),
        .imem_addr_o(imem_addr), .imem_data_i(imem_data),
        .dmem_addr_o(dmem_addr), .dmem_wdata_o(dmem_wdata), .dmem_we_o(dmem_we), .dmem_rdata_i(dmem_rdata),
        .alu_out_o(alu_out), .alu_of_o(alu_of), .alu_zf_o(alu_zf),
        .state_o(state), .instr_done_o(instr_done)
    );

    always @(posedge clk) begin
        imem_data <= rom[imem_addr];
        if (dmem_we) ram[dmem_addr] <= dmem_wdata;
        dmem_rdata <= ram[dmem_addr];
    end

    function automatic logic [31:0] r_ins(input logic [5:0] fn, input logic [4:0] rd, rs, rt, sh);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rt, rs, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rand_ins();
        logic [5:0]  fns [9];
        logic [5:0]  ctl [4];
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h3F};
        ctl = '{6'h04, 6'h05, 6'h02, 6'h3F};
        rs  = 5'($urandom_range(0, 7));
        rt  = 5'($urandom_range(0, 7));
        rd  = 5'($urandom_range(0, 7));
        imm = 16'($urandom);
        case ($urandom_range(0, 9))
            0, 1, 2: return r_ins(fns[$urandom_range(0, 8)], rd, rs, rt, 5'($urandom));
            3:       return i_ins(6'h0C, rt, rs, imm);
            4:       return i_ins(6'h0D, rt, rs, imm);
            5:       return i_ins(6'h23, rt, rs, imm);
            6:       return i_ins(6'h2B, rt, rs, imm);
            7:       return i_ins(ctl[$urandom_range(0, 3)], rt, rs, imm);
            default: return i_ins(6'h08, rt, rs, imm);
        endcase
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) rom[i] = 32'h0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
        m_pc = 8'h0; m_alu = 32'h0; m_of = 1'b0; m_zf = 1'b0;
    endtask

    // Architectural effect of one instruction; returns its expected cycle count and store.
    task automatic model_step(input logic [31:0] ins, output int lat, output bit st,
                              output logic [5:0] sa, output logic [31:0] sd);
        logic [5:0]  op, fn;
        logic [31:0] a, b, simm, zimm, r;
        longint      t;
        bit          upd, of, ld;
        int          dst;
        op = ins[31:26]; fn = ins[5:0];
        a = m_rf[ins[25:21]]; b = m_rf[ins[20:16]];
        simm = {{16{ins[15]}}, ins[15:0]}; zimm = {16'h0, ins[15:0]};
        r = 32'h0; t = 0; upd = 1'b1; of = 1'b0; ld = 1'b0; dst = int'(ins[20:16]);
        lat = 4; st = 1'b0; sa = 6'h0; sd = 32'h0;
        m_pc = m_pc + 8'd4;
        if (op == 6'h00) begin
            dst = int'(ins[15:11]);
            case (fn)
                6'h20: begin t = longint'($signed(a)) + longint'($signed(b)); r = t[31:0]; of = (t != longint'($signed(r))); end
                6'h22: begin t = longint'($signed(a)) - longint'($signed(b)); r = t[31:0]; of = (t != longint'($signed(r))); end
                6'h24: r = a & b;
                6'h25: r = a | b;
                6'h26: r = a ^ b;
                6'h27: r = ~(a | b);
                6'h2A: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                6'h00: r = b << ins[10:6];
                default: begin upd = 1'b0; lat = 3; end
            endcase
        end else begin
            case (op)
                6'h08: begin t = longint'($signed(a)) + longint'($signed(simm)); r = t[31:0]; of = (t != longint'($signed(r))); end
                6'h0C: r = a & zimm;
                6'h0D: r = a | zimm;
                6'h23: begin r = a + simm; ld = 1'b1; lat = 5; end
                6'h2B: begin r = a + simm; st = 1'b1; sa = r[7:2]; sd = b; m_mem[r[7:2]] = b; dst = 0; end
`ifdef MULTI_CYCLE_CPU_BRANCH_EN
                6'h04: begin upd = 1'b0; lat = 3; if (a == b) m_pc = m_pc + 8'(simm << 2); end
                6'h05: begin upd = 1'b0; lat = 3; if (a != b) m_pc = m_pc + 8'(simm << 2); end
                6'h02: begin upd = 1'b0; lat = 3; m_pc = {ins[5:0], 2'b00}; end
`endif
                default: begin upd = 1'b0; lat = 3; end
            endcase
        end
        if (upd) begin m_alu = r; m_of = of; m_zf = (r == 32'h0); end
        if (upd && dst != 0 && !of) m_rf[dst] = ld ? m_mem[r[7:2]] : r;
    endtask

    // Called at the falling edge inside a FETCH cycle; returns at the next instruction's FETCH.
    task automatic run_instr(input string tag);
        logic [31:0] ins, sd, gd;
        logic [5:0]  sa, ga;
        int          lat, n, wecnt;
        bit          st;
        ins = rom[m_pc[7:2]];
        tests++;
        if (state !== 3'd0 || imem_addr !== m_pc[7:2]) begin
            fails++;
            $display("FAIL %s fetch: state=%0d addr=%0d, expected state=0 addr=%0d", tag, state, imem_addr, m_pc[7:2]);
        end
        model_step(ins, lat, st, sa, sd);
        n = 1; wecnt = 0; ga = 6'h0; gd = 32'h0;
        while (instr_done !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
            if (dmem_we === 1'b1) begin wecnt++; ga = dmem_addr; gd = dmem_wdata; end
        end
        tests++;
        if (n != lat) begin
            fails++;
            $display("FAIL %s latency ins=%08h: got %0d cycles, expected %0d", tag, ins, n, lat);
        end
        tests++;
        if (wecnt != int'(st) || (st && (ga !== sa || gd !== sd))) begin
            fails++;
            $display("FAIL %s store ins=%08h: we_cycles=%0d addr=%0d data=%08h, expected %0d/%0d/%08h",
                     tag, ins, wecnt, ga, gd, int'(st), sa, sd);
        end
        tests++;
        if (alu_out !== m_alu || alu_of !== m_of || alu_zf !== m_zf) begin
            fails++;
            $display("FAIL %s alu ins=%08h: out=%08h of=%b zf=%b, expected %08h/%b/%b",
                     tag, ins, alu_out, alu_of, alu_zf, m_alu, m_of, m_zf);
        end
        @(negedge clk);
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 32; i++) begin
            tests++;
            if (dut.rf_q[i] !== m_rf[i]) begin
                fails++;
                $display("FAIL %s r%0d: got %08h, expected %08h", tag, i, dut.rf_q[i], m_rf[i]);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        clear_rom();
        rom[0] = i_ins(6'h08, 5'd1, 5'd0, 16'd5);
        rom[1] = i_ins(6'h08, 5'd2, 5'd0, 16'hFFFD);
        rom[2] = i_ins(6'h08, 5'd3, 5'd0, 16'd9);
        do_reset();
        run_instr("reset_pre");
        run_instr("reset_pre");
        repeat (2) @(negedge clk);
        do_reset();
        tests++;
        if (state !== 3'd0 || imem_addr !== 6'd0 || alu_out !== 32'h0 || alu_of !== 1'b0 ||
            alu_zf !== 1'b0 || instr_done !== 1'b0 || dmem_we !== 1'b0) begin
            fails++;
            $display("FAIL reset outputs: state=%0d addr=%0d alu=%08h of=%b zf=%b done=%b we=%b, expected all zero",
                     state, imem_addr, alu_out, alu_of, alu_zf, instr_done, dmem_we);
        end
        check_regs("reset");
    endtask

    task automatic test_add();
        clear_rom();
        rom[0] = i_ins(6'h08, 5'd1, 5'd0, 16'd5);
        rom[1] = i_ins(6'h08, 5'd2, 5'd0, 16'd7);
        rom[2] = r_ins(6'h20, 5'd3, 5'd1, 5'd2, 5'd0);
        do_reset();
        repeat (3) run_instr("add");
        tests++;
        if (dut.rf_q[3] !== 32'd12 || alu_out !== 32'd12 || alu_zf !== 1'b0) begin
            fails++;
            $display("FAIL add r3: got r3=%08h alu=%08h zf=%b, expected 0000000c/0000000c/0", dut.rf_q[3], alu_out, alu_zf);
        end
        check_regs("add");
    endtask

    task automatic test_overflow();
        clear_rom();
        rom[0] = i_ins(6'h0D, 5'd1, 5'd0, 16'hFFFF);
        rom[1] = r_ins(6'h00, 5'd1, 5'd0, 5'd1, 5'd15);
        rom[2] = i_ins(6'h0D, 5'd1, 5'd1, 16'hFFFF);
        rom[3] = r_ins(6'h20, 5'd2, 5'd1, 5'd1, 5'd0);
        do_reset();
        repeat (4) run_instr("ovf");
        tests++;
        if (alu_of !== 1'b1 || dut.rf_q[2] !== 32'h0 || dut.rf_q[1] !== 32'h7FFFFFFF) begin
            fails++;
            $display("FAIL ovf: of=%b r1=%08h r2=%08h, expected 1/7fffffff/00000000", alu_of, dut.rf_q[1], dut.rf_q[2]);
        end
        check_regs("ovf");
    endtask

    task automatic test_mem();
        clear_rom();
        rom[0] = i_ins(6'h08, 5'd1, 5'd0, 16'd5);
        rom[1] = i_ins(6'h08, 5'd2, 5'd0, 16'd7);
        rom[2] = r_ins(6'h20, 5'd3, 5'd1, 5'd2, 5'd0);
        rom[3] = i_ins(6'h2B, 5'd3, 5'd0, 16'd8);
        rom[4] = i_ins(6'h23, 5'd4, 5'd0, 16'd8);
        do_reset();
        repeat (5) run_instr("mem");
        tests++;
        if (dut.rf_q[4] !== 32'd12 || ram[2] !== 32'd12) begin
            fails++;
            $display("FAIL mem lw: r4=%08h ram[2]=%08h, expected 0000000c/0000000c", dut.rf_q[4], ram[2]);
        end
        check_regs("mem");
    endtask

    task automatic test_nop();
        clear_rom();
        rom[0] = i_ins(6'h08, 5'd1, 5'd0, 16'd9);
        rom[1] = {6'h3F, 26'($urandom)};
        rom[2] = r_ins(6'h3F, 5'd1, 5'd0, 5'd0, 5'd0);
        do_reset();
        repeat (3) run_instr("nop");
        tests++;
        if (dut.rf_q[1] !== 32'd9 || alu_out !== 32'd9) begin
            fails++;
            $display("FAIL nop: r1=%08h alu=%08h, expected 00000009/00000009", dut.rf_q[1], alu_out);
        end
        check_regs("nop");
    endtask

    task automatic test_branch();
        logic [5:0] exp;
        clear_rom();
        rom[4] = i_ins(6'h04, 5'd0, 5'd0, 16'hFFFF);
        do_reset();
        repeat (4) run_instr("br_pre");
        for (int k = 0; k < 3; k++) begin
            run_instr("br");
`ifdef MULTI_CYCLE_CPU_BRANCH_EN
            exp = 6'd4;
`else
            exp = 6'(5 + k);
`endif
            tests++;
            if (imem_addr !== exp) begin
                fails++;
                $display("FAIL branch pc step %0d: got addr %0d, expected %0d", k, imem_addr, exp);
            end
        end
    endtask

    task automatic test_abort();
        clear_rom();
        rom[0] = i_ins(6'h08, 5'd3, 5'd0, 16'd12);
        rom[1] = i_ins(6'h2B, 5'd3, 5'd0, 16'd16);
        do_reset();
        run_instr("abort_pre");
        repeat (3) @(negedge clk);
        tests++;
        if (state !== 3'd3 || dmem_we !== 1'b1) begin
            fails++;
            $display("FAIL abort sw MEM: state=%0d we=%b, expected 3/1", state, dmem_we);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (dmem_we !== 1'b0) begin
            fails++;
            $display("FAIL abort we under reset: got %b, expected 0", dmem_we);
        end
        @(negedge clk);
        tests++;
        if (state !== 3'd0 || imem_addr !== 6'd0) begin
            fails++;
            $display("FAIL abort after reset: state=%0d addr=%0d, expected 0/0", state, imem_addr);
        end
        rst = 1'b0;
        model_reset();
        tests++;
        if (ram[4] !== m_mem[4]) begin
            fails++;
            $display("FAIL abort ram[4]: got %08h, expected %08h", ram[4], m_mem[4]);
        end
        check_regs("abort");
    endtask

    task automatic test_random();
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 64; i++) rom[i] = rand_ins();
            for (int i = 0; i < 7; i++) rom[i] = i_ins(6'h08, 5'(i + 1), 5'd0, 16'($urandom));
            do_reset();
            repeat (60) run_instr("rand");
            check_regs("rand");
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin ram[i] = 32'h0; m_mem[i] = 32'h0; end
        clear_rom();
        model_reset();
        test_reset();
        test_add();
        test_overflow();
        test_mem();
        test_nop();
        test_branch();
        test_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
